// File: rtl/modbus_rtu_tx_framer.sv
// Modbus RTU response framer: buffers a PDU, appends CRC-16/Modbus, paces bytes into uart_tx after the t3.5 gap.
// Optional RS-485 driver enable with lead time is built when RS485_DE_EN is defined.
module modbus_rtu_tx_framer #(
    parameter int MAX_LEN    = 32,
    parameter int GAP_CYCLES = 21000
`ifdef RS485_DE_EN
    ,
    parameter int DE_LEAD    = 104
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       busy,
    output logic       frame_done,
    output logic       overflow
`ifdef RS485_DE_EN
    ,
    output logic       de
`endif
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN + 2);
    localparam int CW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_DISCARD,
        S_GAP,
        S_SEND,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic [7:0]    r_buf [MAX_LEN];
    logic [LW-1:0] r_len;
    logic [IW-1:0] r_idx;
    logic [15:0]   r_crc;
    logic [CW-1:0] r_idle;
    logic          r_tx_start;
    logic          r_start_d;
    logic [7:0]    r_tx_data;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_overflow;

    logic          w_xfer;
    logic          w_line_free;
    logic          w_lead_ok;
    logic          w_full;
    logic [IW-1:0] w_len_x;
    logic [7:0]    w_byte;

    function automatic logic [15:0] f_crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] v;
        v = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ 16'hA001) : (v >> 1);
        end
        return v;
    endfunction

    assign w_xfer      = in_valid && r_in_ready;
    assign w_full      = (r_len == LW'(MAX_LEN));
    assign w_len_x     = IW'(r_len);
    // uart_tx raises busy one cycle late, so the cycle after a start is never trusted
    assign w_line_free = !tx_busy && !r_tx_start && !r_start_d;

    always_comb begin
        w_byte = 8'h00;
        if (r_idx < w_len_x) begin
            w_byte = r_buf[r_idx[AW-1:0]];
        end else if (r_idx == w_len_x) begin
            w_byte = r_crc[7:0];
        end else begin
            w_byte = r_crc[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && w_xfer && !w_full) begin
            r_buf[r_len[AW-1:0]] <= in_data;
        end
    end

    // Line-idle timer runs in every state so a frame queued during the gap still waits it out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= CW'(GAP_CYCLES);
        end else if (tx_busy || r_tx_start) begin
            r_idle <= '0;
        end else if (r_idle != CW'(GAP_CYCLES)) begin
            r_idle <= r_idle + CW'(1);
        end
    end

`ifdef RS485_DE_EN
    localparam int DW = $clog2(DE_LEAD + 1);
    logic [DW-1:0] r_lead;
    logic          r_de;
    assign w_lead_ok = (r_lead == '0);
    assign de        = r_de;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lead <= '0;
            r_de   <= 1'b0;
        end else if (r_state == S_GAP && r_idle >= CW'(GAP_CYCLES)) begin
            r_lead <= DW'(DE_LEAD - 1);
            r_de   <= 1'b1;
        end else if (r_state == S_SEND && r_lead != '0) begin
            r_lead <= r_lead - DW'(1);
        end else if (r_state == S_DRAIN && w_line_free) begin
            r_de   <= 1'b0;
        end
    end
`else
    assign w_lead_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_len        <= '0;
            r_idx        <= '0;
            r_crc        <= 16'hFFFF;
            r_tx_start   <= 1'b0;
            r_start_d    <= 1'b0;
            r_tx_data    <= 8'h00;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_start_d    <= r_tx_start;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_xfer) begin
                        r_busy <= 1'b1;
                        if (w_full) begin
                            if (in_last) begin
                                r_overflow <= 1'b1;
                                r_len      <= '0;
                                r_crc      <= 16'hFFFF;
                                r_busy     <= 1'b0;
                            end else begin
                                r_state <= S_DISCARD;
                            end
                        end else begin
                            r_crc <= f_crc_byte(r_crc, in_data);
                            r_len <= r_len + LW'(1);
                            if (in_last) begin
                                r_state    <= S_GAP;
                                r_in_ready <= 1'b0;
                            end
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_xfer && in_last) begin
                        r_overflow <= 1'b1;
                        r_len      <= '0;
                        r_crc      <= 16'hFFFF;
                        r_busy     <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_GAP: begin
                    if (r_idle >= CW'(GAP_CYCLES)) begin
                        r_idx   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_line_free && w_lead_ok) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_byte;
                        r_idx      <= r_idx + IW'(1);
                        if (r_idx == w_len_x + IW'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_line_free) begin
                        r_frame_done <= 1'b1;
                        r_len        <= '0;
                        r_crc        <= 16'hFFFF;
                        r_busy       <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule
